// File: rtl/mef_dispensador_rolhas.sv
// rtl/mef_dispensador_rolhas.sv - cork magazine dispenser FSM with refill and low-stock flags
module mef_dispensador_rolhas #(
  parameter int CAP  = 20,
  parameter int LOW  = 5,
  parameter int LOTE = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done,
  input  logic       repor,
  output logic       rolha,
  output logic [4:0] count,
  output logic       baixo,
  output logic       vazio,
  output logic       carregando,
  output logic       erro
);

  localparam logic [1:0] OPER  = 2'b00;
  localparam logic [1:0] REPOR = 2'b01;
  localparam logic [1:0] VAZIO = 2'b10;

  localparam logic [4:0] CAP_C  = 5'(CAP);
  localparam logic [4:0] LOW_C  = 5'(LOW);
  localparam logic [4:0] LOTE_C = 5'(LOTE);

  logic [1:0] state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [4:0] added_q, added_d;
  logic       erro_q, erro_d;
  logic       dec, inc;

  // Next-state, magazine count and refill progress
  always_comb begin
    dec     = done && (count_q != 5'd0);
    inc     = (state_q == REPOR) && (count_q < CAP_C);
    state_d = state_q;
    added_d = added_q;
    erro_d  = done && (count_q == 5'd0);

    // Simultaneous load and consume cancel out in the count
    count_d = count_q;
    if (inc && !dec) begin
      count_d = count_q + 5'd1;
    end else if (dec && !inc) begin
      count_d = count_q - 5'd1;
    end

    // A consumed cork during refill still counts as a loaded one
    if (inc) begin
      added_d = added_q + 5'd1;
    end

    case (state_q)
      OPER: begin
        // Refill wins over emptying when both happen together
        if (repor && (count_q < CAP_C)) begin
          state_d = REPOR;
          added_d = 5'd0;
        end else if ((count_q == 5'd1) && dec) begin
          state_d = VAZIO;
        end
      end
      REPOR: begin
        if ((count_q == CAP_C) || (count_d == CAP_C) || (added_d == LOTE_C)) begin
          state_d = OPER;
        end
      end
      VAZIO: begin
        if (repor) begin
          state_d = REPOR;
          added_d = 5'd0;
        end
      end
      default: begin
        state_d = VAZIO;
        count_d = 5'd0;
        added_d = 5'd0;
      end
    endcase
  end

  // State registers with synchronous reset discarding any partial load
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= VAZIO;
      count_q <= 5'd0;
      added_q <= 5'd0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      added_q <= added_d;
      erro_q  <= erro_d;
    end
  end

  // Outputs decoded purely from registered state and count
  always_comb begin
    count      = count_q;
    rolha      = (count_q != 5'd0);
    baixo      = (count_q != 5'd0) && (count_q <= LOW_C);
    vazio      = (state_q == VAZIO);
    carregando = (state_q == REPOR);
    erro       = erro_q;
  end

endmodule

// File: tb/tb_mef_dispensador_rolhas.sv
// tb/tb_mef_dispensador_rolhas.sv - directed table and sequence checks for the cork dispenser
module tb_mef_dispensador_rolhas;

  logic       clk;
  logic       reset;
  logic       done;
  logic       repor;
  logic       rolha;
  logic [4:0] count;
  logic       baixo;
  logic       vazio;
  logic       carregando;
  logic       erro;

  int n_cmp;
  int n_bad;

  mef_dispensador_rolhas #(.CAP(20), .LOW(5), .LOTE(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .done       (done),
    .repor      (repor),
    .rolha      (rolha),
    .count      (count),
    .baixo      (baixo),
    .vazio      (vazio),
    .carregando (carregando),
    .erro       (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       dn;
    logic       rp;
    logic [4:0] c;
    logic       r;
    logic       b;
    logic       v;
    logic       l;
    logic       e;
  } vec_t;

  vec_t tbl[14];

  task automatic step(input logic r, input logic d, input logic p);
    reset = r;
    done  = d;
    repor = p;
    @(posedge clk);
    #1;
    reset = 1'b0;
    done  = 1'b0;
    repor = 1'b0;
  endtask

  task automatic check(input string name, input logic [4:0] c, input logic r, input logic b,
                       input logic v, input logic l, input logic e);
    logic [9:0] got;
    logic [9:0] exp;
    got = {count, rolha, baixo, vazio, carregando, erro};
    exp = {c, r, b, v, l, e};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got count=%0d rolha=%b baixo=%b vazio=%b carregando=%b erro=%b, expected count=%0d rolha=%b baixo=%b vazio=%b carregando=%b erro=%b",
               name, count, rolha, baixo, vazio, carregando, erro, c, r, b, v, l, e);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    done  = 1'b0;
    repor = 1'b0;

    //          rst   dn    rp    count  rolha baixo vazio carr  erro
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // reset
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // reset
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // underflow
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // erro one cycle
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // enter REPOR, no load yet
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 5'd1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // repor ignored, load 1
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // inc+dec cancel
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // reset mid-refill
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // repor+done in VAZIO
    tbl[12] = '{1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].dn, tbl[i].rp);
      check($sformatf("table[%0d]", i), tbl[i].c, tbl[i].r, tbl[i].b, tbl[i].v, tbl[i].l, tbl[i].e);
    end

    // Full 15-cork refill from empty, then drain to empty
    step(1'b0, 1'b0, 1'b1);
    check("fill_entry", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("fill_%0d", i), 5'(i), 1'b1, (i <= 5), 1'b0, (i < 15), 1'b0);
    end
    for (int i = 14; i >= 0; i--) begin
      step(1'b0, 1'b1, 1'b0);
      check($sformatf("drain_%0d", i), 5'(i), (i != 0), (i > 0 && i <= 5), (i == 0), 1'b0, 1'b0);
    end

    // From 10 corks, refill stops at capacity before the batch limit
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    check("at_10", 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("cap_entry", 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 11; i <= 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("cap_fill_%0d", i), 5'(i), 1'b1, 1'b0, 1'b0, (i < 20), 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    check("repor_full_ignored", 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // From 1 cork, a done during refill cancels one load; 15 loads end at 15
    for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 1'b0);
    check("at_1", 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("mix_entry", 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      int exp_c;
      exp_c = (k < 3) ? (1 + k) : k;
      step(1'b0, (k == 3), 1'b0);
      check($sformatf("mix_%0d", k), 5'(exp_c), 1'b1, (exp_c <= 5), 1'b0, (k < 15), 1'b0);
    end

    // Refill request beats the emptying done in the same cycle
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0);
    check("prio_at_1", 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("prio_repor", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("prio_load", 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
